// File: rtl/dcache_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wb_master
// Description : Single-outstanding Wishbone B4 classic master for D-cache
//               MSHR fills and evictions, with bus error / timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wb_master #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_BUS     = 1'b1;
    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;

    logic w_timeout;
    logic w_done;
    logic w_unused_addr_lsb;

    // Byte offset within the word is deliberately dropped.
    assign w_unused_addr_lsb = ^addr_i[1:0];

    assign w_timeout = (state_q == S_BUS) && !wb_ack_i && !wb_err_i && (cnt_q == C_TO_LAST);
    assign w_done    = (state_q == S_BUS) && (wb_ack_i || wb_err_i || w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_i)  state_d = S_BUS;
            S_BUS:   if (w_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        if (state_q == S_IDLE) begin
            if (req_i) begin
                cnt_d = '0;
                cyc_d = 1'b1;
                stb_d = 1'b1;
                we_d  = we_i;
                adr_d = {addr_i[31:2], 2'b00};
                dat_d = we_i ? wdata_i : 32'h0;
                sel_d = 4'hF;
            end
        end else if (w_done) begin
            // Error beats ack; only a clean read ack returns bus data.
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            valid_d = 1'b1;
            err_d   = wb_err_i || w_timeout;
            rdata_d = (!wb_err_i && !w_timeout && !we_q) ? wb_dat_i : 32'h0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign rdata_o  = rdata_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_wb_master
// Description : Randomised self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_wb_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        valid, err, busy;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    dcache_wb_master #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .valid_o  (valid),
        .err_o    (err),
        .busy_o   (busy),
        .wb_cyc_o (wb_cyc),
        .wb_stb_o (wb_stb),
        .wb_we_o  (wb_we),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack),
        .wb_err_i (wb_err)
    );

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave; k = response edge after accept
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wd,
                           input int k, input int kind, input logic [31:0] t_rd, input bit noise);
        int          d;
        logic        e_err;
        logic [31:0] e_rd;
        d     = (kind == 3 || k > TO) ? TO : k;
        e_err = (kind != 0) || (k > TO);
        e_rd  = (e_err || t_we) ? 32'h0 : t_rd;

        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom_range(0, 1)); addr = 32'($urandom); wdata = 32'($urandom);

        n_checks++;
        if (valid !== 1'b0 || rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL accept_prev: valid=%b rdata=%h, required valid=0 rdata=%h", valid, rdata, exp_rdata);
        end
        n_checks++;
        if ({busy, wb_cyc, wb_stb, wb_we} !== {3'b111, t_we}) begin
            n_errors++;
            $display("FAIL accept_ctl: busy/cyc/stb/we=%b, required %b", {busy, wb_cyc, wb_stb, wb_we}, {3'b111, t_we});
        end
        n_checks++;
        if (wb_adr !== {t_addr[31:2], 2'b00} || wb_sel !== 4'hF || wb_dat_o !== (t_we ? t_wd : 32'h0)) begin
            n_errors++;
            $display("FAIL accept_bus: adr=%h sel=%h dat=%h, required adr=%h sel=f dat=%h",
                     wb_adr, wb_sel, wb_dat_o, {t_addr[31:2], 2'b00}, (t_we ? t_wd : 32'h0));
        end

        for (int e = 1; e <= d; e++) begin
            wb_ack   = (e == k) && (kind == 0 || kind == 2);
            wb_err   = (e == k) && (kind == 1 || kind == 2);
            wb_dat_i = (e == k) ? t_rd : 32'($urandom);
            if (noise) req = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            wb_ack = 1'b0; wb_err = 1'b0; req = 1'b0;
            if (e < d) begin
                n_checks++;
                if (valid !== 1'b0 || {busy, wb_cyc, wb_stb} !== 3'b111 || wb_adr !== {t_addr[31:2], 2'b00}) begin
                    n_errors++;
                    $display("FAIL bus_hold e=%0d: valid=%b busy/cyc/stb=%b adr=%h, required 0 111 %h",
                             e, valid, {busy, wb_cyc, wb_stb}, wb_adr, {t_addr[31:2], 2'b00});
                end
            end else begin
                n_checks++;
                if (valid !== 1'b1 || err !== e_err) begin
                    n_errors++;
                    $display("FAIL done_flags: valid=%b err=%b, required valid=1 err=%b", valid, err, e_err);
                end
                n_checks++;
                if (rdata !== e_rd) begin
                    n_errors++;
                    $display("FAIL done_rdata: rdata=%h, required %h", rdata, e_rd);
                end
                n_checks++;
                if ({busy, wb_cyc, wb_stb, wb_we} !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL done_ctl: busy/cyc/stb/we=%b, required 0000", {busy, wb_cyc, wb_stb, wb_we});
                end
            end
        end
        exp_rdata = e_rd;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, valid, err, wb_cyc, wb_stb, wb_we} !== 6'b0 || rdata !== 32'h0 ||
            wb_adr !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_state: flags=%b rdata=%h adr=%h dat=%h sel=%h, required all zero",
                     {busy, valid, err, wb_cyc, wb_stb, wb_we}, rdata, wb_adr, wb_dat_o, wb_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_read();
        run_txn(1'b0, 32'h0000_0103, 32'hDEAD_BEEF, 3, 0, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_write();
        run_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 1, 0, 32'h5555_AAAA, 1'b0);
    endtask

    task automatic test_error();
        run_txn(1'b0, 32'h0000_2000, 32'h0, 2, 2, 32'h7777_7777, 1'b0);
        run_txn(1'b1, 32'h0000_2004, 32'h0BAD_0BAD, 4, 1, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h0000_3000, 32'h0, 0, 3, 32'h0, 1'b0);
        run_txn(1'b0, 32'h0000_3004, 32'h0, TO, 0, 32'h1357_9BDF, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 32'h0000_4000, 32'h0, 1, 0, 32'hA5A5_0001, 1'b0);
        run_txn(1'b1, 32'h0000_4004, 32'hB6B6_0002, 1, 0, 32'h0, 1'b0);
        run_txn(1'b0, 32'h0000_4008, 32'h0, 5, 0, 32'hC7C7_0003, 1'b1);
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb_ack = 1'($urandom_range(0, 1)); wb_err = ~wb_ack | 1'($urandom_range(0, 1));
            wb_dat_i = 32'($urandom);
            @(posedge clk); #1;
            wb_ack = 1'b0; wb_err = 1'b0;
            n_checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || wb_cyc !== 1'b0 || rdata !== exp_rdata) begin
                n_errors++;
                $display("FAIL spurious_ack: valid=%b busy=%b cyc=%b rdata=%h, required 0 0 0 %h",
                         valid, busy, wb_cyc, rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0000_5000;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, wb_cyc, wb_stb, valid} !== 4'b0000 || wb_adr !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: busy/cyc/stb/valid=%b adr=%h, required 0000 0", {busy, wb_cyc, wb_stb, valid}, wb_adr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            wb_ack = 1'b1; wb_dat_i = 32'hFFFF_0000 + 32'(i);
            @(posedge clk); #1;
            n_checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
                n_errors++;
                $display("FAIL post_reset: valid=%b busy=%b rdata=%h, required 0 0 0", valid, busy, rdata);
            end
        end
        wb_ack = 1'b0;
        run_txn(1'b0, 32'h0000_5000, 32'h0, 2, 0, 32'h2468_ACE0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int kind;
            int r;
            r = int'($urandom_range(0, 9));
            kind = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
            run_txn(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
                    int'($urandom_range(1, TO + 2)), kind, 32'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_error();
        test_timeout();
        test_back_to_back();
        test_spurious();
        test_reset_mid_bus();
        test_random();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
